ro_edge_counter: RTL and testbench
==================================

Name: ro_edge_counter

Overview:
- Measurement stage directly downstream of the ring-oscillator inverter chain in the hwdbg sensor path.
- Takes the free-running, asynchronous oscillator tap (after any external divider) and counts its rising edges over a programmable window of system-clock cycles.
- Presents the result as a frequency/delay figure for the debugger's sensor readout logic.
- One-shot measurement per start request, with busy/valid handshake and saturating overflow detection.

Parameters:
- COUNT_WIDTH, 32, width of edge counter and count_out.
- WINDOW_WIDTH, 32, width of window_len and the internal window timer.
- SYNC_STAGES, 2, flip-flop stages in the ro_in synchronizer; legal range 2..4.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- ro_in  input  1  asynchronous oscillator tap; guaranteed high and low each for at least 2 clock periods.
- start  input  1  single-cycle measurement request.
- window_len  input  WINDOW_WIDTH  measurement window in clock cycles; sampled on accepted start.
- busy  output  1  high from the cycle after an accepted start until the cycle count_valid is asserted.
- count_valid  output  1  one-cycle pulse; count_out and overflow are final.
- count_out  output  COUNT_WIDTH  rising-edge count of the last completed window; held until the next accepted start.
- overflow  output  1  set if the count saturated in the last window; held with count_out.

Behaviour:
- Reset: state=IDLE; busy=0; count_valid=0; count_out=0; overflow=0; synchronizer, edge register, window timer and counter all cleared. Reset wins over every other input in the same cycle.
- Synchronizer: SYNC_STAGES flops on ro_in, always running. Edge detect is sync_out=1 and prev=0; prev is the registered sync_out.
- FSM states: IDLE, ARM, MEASURE, DONE.
- IDLE/DONE, start=1:
  - Latch window_len.
  - Clear the counter and overflow; count_out is also cleared.
  - Enter ARM; busy=1 next cycle.
- IDLE/DONE, start=0: remain; DONE returns to IDLE after exactly one cycle.
- ARM:
  - Lasts exactly SYNC_STAGES cycles, which flushes stale synchronizer contents.
  - prev is loaded with sync_out every cycle.
  - No edges are counted in ARM, so a high ro_in at arm time is never a false edge.
  - On leaving ARM: if the latched window is 0, go to DONE; otherwise load the timer with the window and go to MEASURE.
- MEASURE:
  - Lasts exactly window_len cycles.
  - Each cycle with a detected edge increments the counter.
  - At all-ones the counter holds and overflow=1 (saturating).
  - When the timer reaches its final cycle, go to DONE.
- DONE (entry cycle):
  - count_valid=1 and busy=0.
  - count_out and overflow are driven from the final counter value.
  - The edge detected in the last MEASURE cycle is included.
- Latency: start accepted at cycle T gives count_valid at cycle T+1+SYNC_STAGES+window_len.
- start while busy=1 is ignored; no queuing and no effect on the window in progress.
- start in the same cycle as count_valid (DONE) is accepted and begins a new measurement.
- window_len changes after acceptance have no effect.
- Reset mid-ARM or mid-MEASURE: abort, all outputs return to reset values, and no count_valid is produced.
- Maximum countable edges per window is floor(window_len/4)+1 under the ro_in timing guarantee. Faster ro_in is out of spec; the count is undefined but the FSM is unaffected.

Test Plan:
- ro_in period 10 clocks (5 high/5 low), SYNC_STAGES=2, window_len=100, single start -> count_valid exactly 103 cycles after start; count_out=10; overflow=0; busy high for 102 cycles.
- window_len=0, start -> count_valid 3 cycles after start; count_out=0; overflow=0.
- ro_in held at 1 through start and the whole window (window_len=50) -> count_out=0 (no false edge from ARM).
- COUNT_WIDTH=4, ro_in period 4, window_len=100 -> count_out=15; overflow=1. A following start with ro_in=0 and window_len=10 -> count_out=0; overflow=0.
- start pulses asserted every cycle during a window_len=20 measurement -> exactly one count_valid at cycle 23. A start coincident with that count_valid launches a second measurement; busy=1 on the next cycle.
- reset asserted 10 cycles into MEASURE -> next cycle busy=0, count_out=0, overflow=0; no count_valid. A later start measures normally (period-10 ro_in, window 100 -> 10).

Source files
------------

// File: rtl/ro_edge_counter.sv
// ro_edge_counter: counts rising edges of an asynchronous ring-oscillator tap
// over a programmable window of system-clock cycles, one shot per start.
module ro_edge_counter #(
  parameter int COUNT_WIDTH  = 32,
  parameter int WINDOW_WIDTH = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ro_in,
  input  logic                    start,
  input  logic [WINDOW_WIDTH-1:0] window_len,
  output logic                    busy,
  output logic                    count_valid,
  output logic [COUNT_WIDTH-1:0]  count_out,
  output logic                    overflow
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

  state_t                  state, state_nxt;
  logic [SYNC_STAGES-1:0]  sync;
  logic                    sync_out;
  logic                    prev;
  logic                    rise;
  logic [1:0]              arm_cnt;
  logic                    arm_last;
  logic [WINDOW_WIDTH-1:0] window_q;
  logic [WINDOW_WIDTH-1:0] timer;
  logic [COUNT_WIDTH-1:0]  cnt, cnt_nxt;
  logic                    ovf, ovf_nxt;
  logic                    accept;

  assign sync_out    = sync[SYNC_STAGES-1];
  assign rise        = sync_out & ~prev;
  assign arm_last    = (arm_cnt == 2'(SYNC_STAGES - 1));
  assign accept      = ((state == IDLE) || (state == DONE)) && start;
  assign busy        = (state == ARM) || (state == MEASURE);
  assign count_valid = (state == DONE);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: state_nxt = start ? ARM : IDLE;
      ARM: begin
        if (arm_last) state_nxt = (window_q == '0) ? DONE : MEASURE;
      end
      MEASURE: begin
        if (timer == WINDOW_WIDTH'(1)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating edge counter next value; cleared on an accepted start
  always_comb begin
    cnt_nxt = cnt;
    ovf_nxt = ovf;
    if (accept) begin
      cnt_nxt = '0;
      ovf_nxt = 1'b0;
    end else if ((state == MEASURE) && rise) begin
      if (cnt == '1) ovf_nxt = 1'b1;
      else           cnt_nxt = cnt + 1'b1;
    end
  end

  // Free-running synchronizer and edge-history register
  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ro_in};
      prev <= sync_out;
    end
  end

  // Window latch, ARM-phase counter and window timer
  always_ff @(posedge clock) begin
    if (reset) begin
      window_q <= '0;
      arm_cnt  <= '0;
      timer    <= '0;
    end else begin
      if (accept) begin
        window_q <= window_len;
        arm_cnt  <= '0;
      end else if (state == ARM) begin
        arm_cnt <= arm_cnt + 1'b1;
        if (arm_last) timer <= window_q;
      end else if (state == MEASURE) begin
        timer <= timer - 1'b1;
      end
    end
  end

  // Counter state and result registers; results captured on entry to DONE
  // from the next counter value so the final MEASURE-cycle edge is included
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      ovf       <= 1'b0;
      count_out <= '0;
      overflow  <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
      if (accept) begin
        count_out <= '0;
        overflow  <= 1'b0;
      end else if ((state_nxt == DONE) && (state != DONE)) begin
        count_out <= cnt_nxt;
        overflow  <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ro_edge_counter.sv
// Directed bench for ro_edge_counter: one default-width instance and one
// 4-bit-counter instance for the saturation cases.
`timescale 1ns/1ps
module tb_ro_edge_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ro1, ro2;
  logic        start1, start2;
  logic [31:0] wl1, wl2;
  logic        busy1, busy2, cv1, cv2, ovf1, ovf2;
  logic [31:0] cnt1;
  logic [3:0]  cnt2;

  int ro_half1 = 5, ro_hold1 = 0;
  int ro_half2 = 0, ro_hold2 = 0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  ro_edge_counter #(.COUNT_WIDTH(32), .WINDOW_WIDTH(32), .SYNC_STAGES(2)) dut1 (
    .clock(clk), .reset(reset), .ro_in(ro1), .start(start1), .window_len(wl1),
    .busy(busy1), .count_valid(cv1), .count_out(cnt1), .overflow(ovf1));

  ro_edge_counter #(.COUNT_WIDTH(4), .WINDOW_WIDTH(32), .SYNC_STAGES(2)) dut2 (
    .clock(clk), .reset(reset), .ro_in(ro2), .start(start2), .window_len(wl2),
    .busy(busy2), .count_valid(cv2), .count_out(cnt2), .overflow(ovf2));

  // Oscillator taps, deliberately offset from the clock edges
  initial begin
    ro1 = 1'b0;
    #3;
    forever begin
      if (ro_half1 == 0) begin ro1 = ro_hold1[0]; #10; end
      else begin #(ro_half1 * 10); ro1 = ~ro1; end
    end
  end

  initial begin
    ro2 = 1'b0;
    #7;
    forever begin
      if (ro_half2 == 0) begin ro2 = ro_hold2[0]; #10; end
      else begin #(ro_half2 * 10); ro2 = ~ro2; end
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One start on dut1; returns latency to count_valid (-1 on timeout) and busy cycles
  task automatic measure1(input int w, output int lat, output int busy_n);
    lat = -1;
    busy_n = 0;
    @(negedge clk);
    start1 = 1'b1;
    wl1 = w;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (k == 1) begin start1 = 1'b0; wl1 = w + 7; end
      if (cv1) begin lat = k; break; end
      if (busy1) busy_n++;
    end
  endtask

  task automatic measure2(input int w, output int lat);
    lat = -1;
    @(negedge clk);
    start2 = 1'b1;
    wl2 = w;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (k == 1) begin start2 = 1'b0; wl2 = w + 3; end
      if (cv2) begin lat = k; break; end
    end
  endtask

  initial begin
    int lat, bn, nvalid;
    reset = 1'b1;
    start1 = 1'b0; start2 = 1'b0;
    wl1 = 0; wl2 = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy1, 0);
    check("rst_valid", cv1, 0);
    check("rst_count", cnt1, 0);
    check("rst_ovf", ovf1, 0);
    check("rst_count2", cnt2, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Period-10 tap, window 100
    measure1(100, lat, bn);
    check("w100_latency", lat, 103);
    check("w100_busy_cycles", bn, 102);
    check("w100_count", cnt1, 10);
    check("w100_ovf", ovf1, 0);
    repeat (5) @(negedge clk);
    check("hold_count", cnt1, 10);
    check("hold_valid", cv1, 0);
    check("hold_busy", busy1, 0);

    // Zero window
    measure1(0, lat, bn);
    check("w0_latency", lat, 3);
    check("w0_busy_cycles", bn, 2);
    check("w0_count", cnt1, 0);
    check("w0_ovf", ovf1, 0);

    // Tap held high through arm and window
    ro_half1 = 0; ro_hold1 = 1;
    repeat (4) @(negedge clk);
    measure1(50, lat, bn);
    check("high_latency", lat, 53);
    check("high_count", cnt1, 0);

    // Saturation on the 4-bit instance, then a clean zero-edge window
    ro_half2 = 2;
    measure2(100, lat);
    check("sat_latency", lat, 103);
    check("sat_count", cnt2, 15);
    check("sat_ovf", ovf2, 1);
    ro_half2 = 0; ro_hold2 = 0;
    repeat (5) @(negedge clk);
    measure2(10, lat);
    check("clr_latency", lat, 13);
    check("clr_count", cnt2, 0);
    check("clr_ovf", ovf2, 0);

    // Start held high throughout a window-20 measurement
    ro_half1 = 5;
    repeat (20) @(negedge clk);
    nvalid = 0;
    lat = -1;
    bn = -1;
    start1 = 1'b1;
    wl1 = 20;
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      wl1 = 5;
      if (cv1) begin nvalid++; lat = k; bn = int'(cnt1); end
    end
    check("spam_nvalid", nvalid, 1);
    check("spam_latency", lat, 23);
    check("spam_count", bn, 2);
    @(negedge clk);
    start1 = 1'b0;
    check("restart_busy", busy1, 1);
    check("restart_valid", cv1, 0);
    lat = -1;
    for (int k = 25; k <= 200; k++) begin
      @(negedge clk);
      if (cv1) begin lat = k; break; end
    end
    check("restart_latency", lat, 31);

    // Reset 10 cycles into MEASURE
    repeat (5) @(negedge clk);
    start1 = 1'b1;
    wl1 = 100;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) start1 = 1'b0;
    end
    check("pre_abort_busy", busy1, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy1, 0);
    check("abort_valid", cv1, 0);
    check("abort_count", cnt1, 0);
    check("abort_ovf", ovf1, 0);
    nvalid = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (cv1 || busy1) nvalid++;
    end
    check("abort_quiet", nvalid, 0);
    measure1(100, lat, bn);
    check("post_latency", lat, 103);
    check("post_count", cnt1, 10);
    check("post_ovf", ovf1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
